// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the hex display controller.
package hex_disp_pkg;

   // All segments off (active-low)
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int unsigned NDIG_DEF      = 8;
   localparam int unsigned BLINK_DIV_DEF = 25000000;

   typedef enum logic {
      StIdle = 1'b0,
      StScan = 1'b1
   } state_e;

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Value-transfer handshake between the requester and the display controller.
interface hex_display_ctrl_if
   import hex_disp_pkg::*;
#(
   parameter int unsigned NDIG = NDIG_DEF
);
   logic [4*NDIG-1:0] iData;
   logic              iValid;
   logic              iBlankEn;
   logic              oReady;
   logic              oBusy;

   modport master (
      output iData,
      output iValid,
      output iBlankEn,
      input  oReady,
      input  oBusy
   );

   modport slave (
      input  iData,
      input  iValid,
      input  iBlankEn,
      output oReady,
      output oBusy
   );
endinterface

// File: rtl/blink_prescaler.sv
// Free-running divider producing the blink phase (1 = visible).
module blink_prescaler #(
   parameter int unsigned BLINK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_phase
);

   localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;

   // Count to BLINK_DIV-1, wrap and toggle phase
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign o_phase = r_phase;

endmodule

// File: rtl/decoder7.sv
// Hex nibble to active-low seven-segment pattern, bit 6 = g ... bit 0 = a.
module decoder7 (
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Pure lookup table
   always_comb begin
      o_seg = 7'h7F;
      unique case (i_nibble)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
         default: o_seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Eight-digit hex display controller: latches a word, then scans it MSB-first
// through one shared decoder into per-digit segment registers.
module hex_display_ctrl
   import hex_disp_pkg::*;
#(
   parameter int unsigned NDIG      = NDIG_DEF,
   parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   hex_display_ctrl_if.slave    bus,
   input  logic                 iBlinkEn,
   output logic [7*NDIG-1:0]    oHEX
);

   localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

   state_e                  r_state, w_state_d;
   logic [4*NDIG-1:0]       r_shadow, w_shadow_d;
   logic                    r_blank, w_blank_d;
   logic                    r_seen_nz, w_seen_nz_d;
   logic [IDX_W-1:0]        r_idx, w_idx_d;
   logic [NDIG-1:0][6:0]    r_digits, w_digits_d;
   logic [3:0]              w_nibble;
   logic [6:0]              w_seg;
   logic                    w_phase;

   assign w_nibble = r_shadow[4*r_idx +: 4];

   decoder7 u_decoder7 (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   blink_prescaler #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink_prescaler (
      .i_clk   (iCLK),
      .i_rst   (iRST),
      .o_phase (w_phase)
   );

   // Next-state: accept in idle, write one digit per cycle while scanning
   always_comb begin
      w_state_d   = r_state;
      w_shadow_d  = r_shadow;
      w_blank_d   = r_blank;
      w_seen_nz_d = r_seen_nz;
      w_idx_d     = r_idx;
      w_digits_d  = r_digits;
      unique case (r_state)
         StIdle: begin
            if (bus.iValid) begin
               w_shadow_d  = bus.iData;
               w_blank_d   = bus.iBlankEn;
               w_seen_nz_d = 1'b0;
               w_idx_d     = IDX_LAST;
               w_state_d   = StScan;
            end
         end
         StScan: begin
            // Digit 0 is never blanked so a zero value still shows "0"
            if (r_blank && (w_nibble == 4'h0) && !r_seen_nz && (r_idx != '0)) begin
               w_digits_d[r_idx] = SEG_BLANK;
            end else begin
               w_digits_d[r_idx] = w_seg;
               w_seen_nz_d       = r_seen_nz | (w_nibble != 4'h0);
            end
            if (r_idx == '0) begin
               w_state_d = StIdle;
            end else begin
               w_idx_d = r_idx - 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state   <= StIdle;
         r_shadow  <= '0;
         r_blank   <= 1'b0;
         r_seen_nz <= 1'b0;
         r_idx     <= '0;
         r_digits  <= {NDIG{SEG_BLANK}};
      end else begin
         r_state   <= w_state_d;
         r_shadow  <= w_shadow_d;
         r_blank   <= w_blank_d;
         r_seen_nz <= w_seen_nz_d;
         r_idx     <= w_idx_d;
         r_digits  <= w_digits_d;
      end
   end

   assign bus.oReady = (r_state == StIdle);
   assign bus.oBusy  = (r_state != StIdle);

   // Blink masks the outputs only; digit registers keep their pattern
   always_comb begin
      oHEX = r_digits;
      if (iBlinkEn && !w_phase) begin
         oHEX = '1;
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: per-cycle compare against a value-level model
// plus literal expectations for the documented scenarios.
module tb_hex_display_ctrl;
   import hex_disp_pkg::*;

   localparam int NDIG      = 8;
   localparam int BLINK_DIV = 4;

   logic             iCLK = 1'b0;
   logic             iRST = 1'b1;
   logic             iBlinkEn = 1'b0;
   logic [7*NDIG-1:0] oHEX;

   hex_display_ctrl_if #(.NDIG(NDIG)) bus ();

   hex_display_ctrl #(
      .NDIG      (NDIG),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .bus      (bus),
      .iBlinkEn (iBlinkEn),
      .oHEX     (oHEX)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [6:0]  m_digits [NDIG];
   logic [6:0]  m_target [NDIG];
   bit          m_scan = 1'b0;
   int          m_k = 0;
   int unsigned m_cyc = 0;
   bit          m_ok = 1'b0;

   always @(posedge iCLK) begin
      logic [31:0] d;
      bit          lz;
      if (iRST) begin
         for (int k = 0; k < NDIG; k++) m_digits[k] = 7'h7F;
         m_scan = 1'b0;
         m_k    = 0;
         m_cyc  = 0;
         m_ok   = 1'b1;
      end else begin
         m_cyc++;
         if (m_scan) begin
            m_digits[m_k] = m_target[m_k];
            if (m_k == 0) m_scan = 1'b0;
            else m_k--;
         end else if (bus.iValid) begin
            d = bus.iData;
            for (int k = 0; k < NDIG; k++) begin
               lz = 1'b1;
               for (int j = k; j < NDIG; j++) if (d[4*j +: 4] != 4'h0) lz = 1'b0;
               m_target[k] = (bus.iBlankEn && k != 0 && lz) ? 7'h7F : seg_tab[d[4*k +: 4]];
            end
            m_scan = 1'b1;
            m_k    = NDIG - 1;
         end
      end
   end

   function automatic logic [7*NDIG-1:0] model_hex();
      logic [7*NDIG-1:0] e;
      for (int k = 0; k < NDIG; k++) e[7*k +: 7] = m_digits[k];
      if (iBlinkEn && (((m_cyc / BLINK_DIV) % 2) == 1)) e = '1;
      return e;
   endfunction

   // Per-cycle comparison on the falling edge
   always @(negedge iCLK) begin
      if (m_ok) begin
         check("oHEX_model", oHEX, model_hex());
         check("oReady_model", bus.oReady, !m_scan);
         check("oBusy_model", bus.oBusy, m_scan);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge iCLK);
      #2;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.oReady && n < 30) begin
         step();
         n++;
      end
      if (!bus.oReady) begin
         n_checks++;
         n_errors++;
         $display("FAIL ready_timeout: got oReady=0 expected 1 within 30 cycles");
      end
   endtask

   task automatic send(input logic [31:0] d, input logic b);
      int n;
      bus.iData    = d;
      bus.iBlankEn = b;
      bus.iValid   = 1'b1;
      wait_ready(n);
      step();
      bus.iValid = 1'b0;
   endtask

   localparam logic [55:0] ALL_OFF = {56{1'b1}};

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end

   initial begin
      int n;
      int run;
      bit found;
      logic [55:0] pat;
      bus.iData    = '0;
      bus.iValid   = 1'b0;
      bus.iBlankEn = 1'b0;

      // 1: reset and idle
      iRST = 1'b1;
      step();
      step();
      iRST = 1'b0;
      check("reset_hex", oHEX, ALL_OFF);
      check("reset_ready", bus.oReady, 1'b1);
      check("reset_busy", bus.oBusy, 1'b0);
      repeat (10) step();
      check("idle_hex", oHEX, ALL_OFF);

      // 2: no blanking, latency and MSB-first order
      send(32'h0000_0012, 1'b0);
      check("t2_d7_before", oHEX[55:49], 7'h7F);
      check("t2_busy_after_xfer", bus.oReady, 1'b0);
      step();
      check("t2_d7_first", oHEX[55:49], 7'h40);
      check("t2_d6_not_yet", oHEX[48:42], 7'h7F);
      wait_ready(n);
      check("t2_low_cycles", 1 + n, 8);
      check("t2_hex", oHEX, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24});

      // 3: blanking cases
      send(32'h0000_0012, 1'b1);
      wait_ready(n);
      check("t3_blank12", oHEX, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24});
      send(32'h0000_0000, 1'b1);
      wait_ready(n);
      check("t3_blank0", oHEX, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      send(32'h8000_0003, 1'b1);
      wait_ready(n);
      check("t3_blank8003", oHEX, {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30});

      // 4: ignored mid-scan valid, then back-to-back hold
      send(32'hFFFF_FFFF, 1'b0);
      step();
      step();
      bus.iData  = 32'h0;
      bus.iValid = 1'b1;
      step();
      bus.iValid = 1'b0;
      wait_ready(n);
      check("t4_allF", oHEX, {8{7'h0E}});
      send(32'hFFFF_FFFF, 1'b0);
      bus.iData  = 32'hAAAA_AAAA;
      bus.iValid = 1'b1;
      wait_ready(n);
      check("t4_gap", n, 8);
      step();
      bus.iValid = 1'b0;
      check("t4_accepted", bus.oReady, 1'b0);
      check("t4_still_F", oHEX, {8{7'h0E}});
      wait_ready(n);
      check("t4_allA", oHEX, {8{7'h08}});

      // 5: blink
      send(32'h0000_0012, 1'b0);
      wait_ready(n);
      pat = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24};
      iBlinkEn = 1'b1;
      #1;
      n = 0;
      while (oHEX == ALL_OFF && n < 20) begin step(); n++; end
      n = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         step();
         n++;
         if (oHEX == ALL_OFF) found = 1'b1;
      end
      check("t5_dark_seen", found, 1'b1);
      run = 0;
      while (oHEX == ALL_OFF && run < 10) begin step(); run++; end
      check("t5_dark_len", run, BLINK_DIV);
      check("t5_lit_pattern", oHEX, pat);
      n = 0;
      while (oHEX != ALL_OFF && n < 20) begin step(); n++; end
      check("t5_lit_len", n, BLINK_DIV);
      step();
      iBlinkEn = 1'b0;
      #1;
      check("t5_drop_blink", oHEX, pat);

      // 6: reset mid-scan
      send(32'h0000_0000, 1'b0);
      wait_ready(n);
      check("t6_all0", oHEX, {8{7'h40}});
      send(32'h1111_1111, 1'b0);
      step();
      step();
      step();
      iRST = 1'b1;
      step();
      iRST = 1'b0;
      check("t6_reset_hex", oHEX, ALL_OFF);
      check("t6_reset_ready", bus.oReady, 1'b1);
      send(32'h0000_0002, 1'b1);
      wait_ready(n);
      check("t6_after", oHEX, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24});

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
